// File: rtl/twa_pkg.sv
// Shared definitions for the threewire arbiter: FSM encoding, default bus
// widths matching threewire_master_ctrl, and a constant clog2 helper.
package twa_pkg;

    localparam int unsigned TWA_DEF_ADDRESS_BITS  = 10;
    localparam int unsigned TWA_DEF_DATA_BITS     = 32;
    localparam int unsigned TWA_DEF_START_TIMEOUT = 255;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStart  = 2'd1,
        StXfer   = 2'd2,
        StAckGap = 2'd3
    } twa_state_e;

    // Ceiling log2, never less than 1 so it can size a port directly.
    function automatic int unsigned twa_clog2(input int unsigned value);
        int unsigned res;
        res = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request found searching
// upward from ptr, wrapping at NUM_REQ.
module rr_arbiter import twa_pkg::*; #(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned ID_BITS = twa_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_BITS-1:0] ptr,
    output logic [ID_BITS-1:0] grant_idx,
    output logic               grant_valid
);

    int unsigned idx;

    // Scan NUM_REQ candidates starting at ptr; ptr is always kept < NUM_REQ.
    always_comb begin
        idx         = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && req[idx[ID_BITS-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[ID_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/threewire_arbiter.sv
// Shares one threewire master between NUM_REQ requesters. The winner's request
// is captured at grant, the master is sequenced start -> in-progress -> done,
// and a one-cycle ack (or err on start timeout) goes back to the winner.
module threewire_arbiter import twa_pkg::*; #(
    parameter int unsigned  NUM_REQ           = 4,
    parameter int unsigned  TWA_ADDRESS_BITS  = TWA_DEF_ADDRESS_BITS,
    parameter int unsigned  TWA_DATA_BITS     = TWA_DEF_DATA_BITS,
    parameter int unsigned  TWA_START_TIMEOUT = TWA_DEF_START_TIMEOUT,
    localparam int unsigned ID_BITS           = twa_clog2(NUM_REQ)
) (
    input  logic                                in_clk,
    input  logic                                in_rst_n,
    input  logic [NUM_REQ-1:0]                  in_req,
    input  logic [NUM_REQ-1:0]                  in_req_mode_wr,
    input  logic [NUM_REQ*TWA_ADDRESS_BITS-1:0] in_req_addr,
    input  logic [NUM_REQ*TWA_DATA_BITS-1:0]    in_req_wr_data,
    output logic [NUM_REQ-1:0]                  out_ack,
    output logic [NUM_REQ-1:0]                  out_err,
    output logic [TWA_DATA_BITS-1:0]            out_rd_data,
    output logic [ID_BITS-1:0]                  out_grant_id,
    output logic                                out_busy,
    output logic                                out_m_start,
    output logic                                out_m_mode_wr,
    output logic [TWA_ADDRESS_BITS-1:0]         out_m_addr,
    output logic [TWA_DATA_BITS-1:0]            out_m_wr_data,
    input  logic [TWA_DATA_BITS-1:0]            in_m_rd_data,
    input  logic                                in_m_in_progress
);

    localparam int unsigned         CNT_BITS = twa_clog2(TWA_START_TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TWA_START_TIMEOUT - 1);

    twa_state_e                  state_q, state_d;
    logic [CNT_BITS-1:0]         cnt_q, cnt_d;
    // ptr holds the index with top priority at the next arbitration.
    logic [ID_BITS-1:0]          ptr_q, ptr_d;
    logic [ID_BITS-1:0]          grant_q, grant_d;
    logic                        busy_q, busy_d;
    logic [NUM_REQ-1:0]          ack_q, ack_d;
    logic [NUM_REQ-1:0]          err_q, err_d;
    logic [TWA_DATA_BITS-1:0]    rd_q, rd_d;
    logic                        start_q, start_d;
    logic                        mode_q, mode_d;
    logic [TWA_ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [TWA_DATA_BITS-1:0]    wdata_q, wdata_d;

    logic [ID_BITS-1:0]          pick_idx;
    logic                        pick_valid;
    int unsigned                 pick_int;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req         (in_req),
        .ptr         (ptr_q),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    assign pick_int = 32'(pick_idx);

    // Next-state logic: capture at grant, drive start, wait for the master, respond.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        ack_d   = '0;
        err_d   = '0;
        rd_d    = rd_q;
        start_d = start_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    mode_d  = in_req_mode_wr[pick_idx];
                    addr_d  = in_req_addr[pick_int*TWA_ADDRESS_BITS +: TWA_ADDRESS_BITS];
                    wdata_d = in_req_wr_data[pick_int*TWA_DATA_BITS +: TWA_DATA_BITS];
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (in_m_in_progress) begin
                    start_d = 1'b0;
                    state_d = StXfer;
                end else if (cnt_q == CNT_LAST) begin
                    start_d        = 1'b0;
                    err_d[grant_q] = 1'b1;
                    state_d        = StAckGap;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            StXfer: begin
                if (!in_m_in_progress) begin
                    if (!mode_q) begin
                        rd_d = in_m_rd_data;
                    end
                    ack_d[grant_q] = 1'b1;
                    state_d        = StAckGap;
                end
            end
            StAckGap: begin
                busy_d  = 1'b0;
                ptr_d   = (grant_q == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            rd_q    <= '0;
            start_q <= 1'b0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            start_q <= start_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign out_ack       = ack_q;
    assign out_err       = err_q;
    assign out_rd_data   = rd_q;
    assign out_grant_id  = grant_q;
    assign out_busy      = busy_q;
    assign out_m_start   = start_q;
    assign out_m_mode_wr = mode_q;
    assign out_m_addr    = addr_q;
    assign out_m_wr_data = wdata_q;

endmodule

// File: tb/tb_threewire_arbiter.sv
// Scoreboard bench for threewire_arbiter: stimulus pushes expected bus and
// response records; a master model and a response monitor pop and compare.
module tb_threewire_arbiter;
    import twa_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 255;

    logic            in_clk = 1'b0;
    logic            in_rst_n;
    logic [N-1:0]    in_req, in_req_mode_wr;
    logic [N*AW-1:0] in_req_addr;
    logic [N*DW-1:0] in_req_wr_data;
    logic [N-1:0]    out_ack, out_err;
    logic [DW-1:0]   out_rd_data, out_m_wr_data;
    logic [DW-1:0]   in_m_rd_data = '0;
    logic [1:0]      out_grant_id;
    logic            out_busy, out_m_start, out_m_mode_wr;
    logic            in_m_in_progress = 1'b0;
    logic [AW-1:0]   out_m_addr;

    typedef struct packed {
        logic          mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdret;
    } bus_t;

    typedef struct packed {
        int unsigned   id;
        logic          err;
        logic [DW-1:0] rd;
    } rsp_t;

    bus_t          exp_bus_q[$];
    rsp_t          exp_rsp_q[$];
    bus_t          mdl_b;
    rsp_t          mon_r;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    logic          start_prev = 1'b0;
    int            xfer_len = 3;
    logic          slave_en = 1'b1;
    int            act_left = 0;
    logic [DW-1:0] cur_ret = '0;
    logic [DW-1:0] model_rd = '0;

    threewire_arbiter #(
        .NUM_REQ           (N),
        .TWA_ADDRESS_BITS  (AW),
        .TWA_DATA_BITS     (DW),
        .TWA_START_TIMEOUT (TO)
    ) dut (
        .in_clk           (in_clk),
        .in_rst_n         (in_rst_n),
        .in_req           (in_req),
        .in_req_mode_wr   (in_req_mode_wr),
        .in_req_addr      (in_req_addr),
        .in_req_wr_data   (in_req_wr_data),
        .out_ack          (out_ack),
        .out_err          (out_err),
        .out_rd_data      (out_rd_data),
        .out_grant_id     (out_grant_id),
        .out_busy         (out_busy),
        .out_m_start      (out_m_start),
        .out_m_mode_wr    (out_m_mode_wr),
        .out_m_addr       (out_m_addr),
        .out_m_wr_data    (out_m_wr_data),
        .in_m_rd_data     (in_m_rd_data),
        .in_m_in_progress (in_m_in_progress)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Master model: accepts a start, holds in_progress for xfer_len cycles.
    always @(negedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            in_m_in_progress = 1'b0;
            act_left         = 0;
        end else if (act_left > 0) begin
            check("start_overlap", 64'(out_m_start), 64'd0);
            act_left--;
            if (act_left == 0) begin
                in_m_in_progress = 1'b0;
                in_m_rd_data     = cur_ret;
            end
        end else if (out_m_start && slave_en) begin
            if (exp_bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: addr %0h with no transfer outstanding", out_m_addr);
            end else begin
                mdl_b = exp_bus_q.pop_front();
                check("bus_mode", 64'(out_m_mode_wr), 64'(mdl_b.mode));
                check("bus_addr", 64'(out_m_addr), 64'(mdl_b.addr));
                if (mdl_b.mode) begin
                    check("bus_wdata", 64'(out_m_wr_data), 64'(mdl_b.wdata));
                end
                cur_ret = mdl_b.rdret;
            end
            in_m_in_progress = 1'b1;
            act_left         = xfer_len;
        end
    end

    // Response monitor: every ack/err cycle must match the next expected response.
    always @(negedge in_clk) begin
        cyc++;
        if (in_rst_n) begin
            if (out_m_start && !start_prev) begin
                start_cyc = cyc;
            end
            if ((out_ack | out_err) != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: ack %b err %b with nothing outstanding",
                             out_ack, out_err);
                end else begin
                    mon_r = exp_rsp_q.pop_front();
                    check("rsp_ack", 64'(out_ack), mon_r.err ? 64'd0 : (64'd1 << mon_r.id));
                    check("rsp_err", 64'(out_err), mon_r.err ? (64'd1 << mon_r.id) : 64'd0);
                    check("rsp_grant_id", 64'(out_grant_id), 64'(mon_r.id));
                    check("rsp_rd_data", 64'(out_rd_data), 64'(mon_r.rd));
                    if (mon_r.err) begin
                        check("timeout_latency", 64'(cyc - start_cyc), 64'(TO));
                    end
                end
            end
        end
        start_prev = out_m_start;
    end

    // One cycle; requesters drop req on the cycle they see their ack/err.
    task automatic step();
        @(negedge in_clk);
        for (int i = 0; i < N; i++) begin
            if (out_ack[i] || out_err[i]) in_req[i] = 1'b0;
        end
    endtask

    task automatic issue(input int unsigned id, input logic mode, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rdret,
                         input logic exp_err);
        bus_t b;
        rsp_t r;
        in_req_mode_wr[id]            = mode;
        in_req_addr[id*AW +: AW]      = addr;
        in_req_wr_data[id*DW +: DW]   = wdata;
        if (!exp_err) begin
            if (!mode) model_rd = rdret;
            b.mode  = mode;
            b.addr  = addr;
            b.wdata = wdata;
            b.rdret = rdret;
            exp_bus_q.push_back(b);
        end
        r.id  = id;
        r.err = exp_err;
        r.rd  = model_rd;
        exp_rsp_q.push_back(r);
        in_req[id] = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_rsp_q.size() != 0 || in_req != '0 || out_busy) && n < budget) begin
            step();
            n++;
        end
        check({name, "_done_in_time"}, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_ack(input int unsigned id, input int budget);
        int n = 0;
        while (!out_ack[id] && n < budget) begin
            step();
            n++;
        end
        check("ack_in_time", 64'(n < budget), 64'd1);
    endtask

    initial begin
        in_req         = '0;
        in_req_mode_wr = '0;
        in_req_addr    = '0;
        in_req_wr_data = '0;
        in_rst_n       = 1'b1;
        #1 in_rst_n    = 1'b0;
        repeat (2) step();
        check("reset_ctrl", 64'({out_ack, out_err, out_grant_id, out_busy, out_m_start,
                                 out_m_mode_wr, out_m_addr}), 64'd0);
        check("reset_rd_data", 64'(out_rd_data), 64'd0);
        check("reset_m_wr_data", 64'(out_m_wr_data), 64'd0);
        in_rst_n = 1'b1;
        step();

        // Single read on requester 2; start must follow one cycle after req.
        issue(2, 1'b0, 10'h155, 32'h0, 32'hDEADBEEF, 1'b0);
        check("read_start_before_grant", 64'(out_m_start), 64'd0);
        step();
        check("read_start_latency", 64'(out_m_start), 64'd1);
        check("read_grant_id", 64'(out_grant_id), 64'd2);
        check("read_busy", 64'(out_busy), 64'd1);
        wait_done("read", 50);

        // Single write; the master's rd_data must not be captured.
        issue(0, 1'b1, 10'h3FF, 32'hA5A5A5A5, 32'h0BADF00D, 1'b0);
        wait_done("write", 50);
        check("write_rd_unchanged", 64'(out_rd_data), 64'hDEADBEEF);

        // Contention from the reset pointer: served 0,1,2,3.
        in_rst_n = 1'b0;
        step();
        in_rst_n = 1'b1;
        model_rd = '0;
        step();
        issue(0, 1'b0, 10'h001, 32'h0,         32'h11111111, 1'b0);
        issue(1, 1'b1, 10'h002, 32'h22222222, 32'h0,        1'b0);
        issue(2, 1'b0, 10'h0AA, 32'h0,         32'h33333333, 1'b0);
        issue(3, 1'b1, 10'h200, 32'h44444444, 32'h0,        1'b0);
        wait_done("contention", 200);

        // Fairness: requester 1 re-asserts after each ack; 3 still gets in next.
        issue(1, 1'b0, 10'h011, 32'h0,         32'h11110001, 1'b0);
        issue(3, 1'b1, 10'h033, 32'h33330000, 32'h0,        1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_ack(1, 100);
            step();
            issue(1, 1'b0, AW'(10'h012 + k), 32'h0, 32'h11110002 + k, 1'b0);
        end
        wait_done("fairness", 200);

        // Start timeout: master never responds.
        slave_en = 1'b0;
        issue(2, 1'b0, 10'h0AB, 32'h0, 32'h0, 1'b1);
        wait_done("timeout", TO + 50);
        check("timeout_busy_low", 64'(out_busy), 64'd0);
        check("timeout_start_low", 64'(out_m_start), 64'd0);
        slave_en = 1'b1;
        issue(2, 1'b0, 10'h0AC, 32'h0, 32'h5EED5EED, 1'b0);
        wait_done("after_timeout", 50);

        // Reset in the middle of a long read.
        xfer_len = 10;
        issue(3, 1'b0, 10'h2C3, 32'h0, 32'hCAFEF00D, 1'b0);
        begin
            int n = 0;
            while (!in_m_in_progress && n < 20) begin
                step();
                n++;
            end
            check("midreset_xfer_started", 64'(in_m_in_progress), 64'd1);
        end
        repeat (2) step();
        in_rst_n = 1'b0;
        #1;
        check("midreset_ctrl", 64'({out_ack, out_err, out_grant_id, out_busy, out_m_start,
                                    out_m_mode_wr, out_m_addr}), 64'd0);
        check("midreset_rd_data", 64'(out_rd_data), 64'd0);
        check("midreset_m_wr_data", 64'(out_m_wr_data), 64'd0);
        exp_rsp_q.delete();
        exp_bus_q.delete();
        in_req = '0;
        step();
        in_rst_n = 1'b1;
        xfer_len = 3;
        model_rd = '0;
        repeat (3) step();
        issue(1, 1'b0, 10'h0F0, 32'h0, 32'h600DCAFE, 1'b0);
        wait_done("after_reset", 50);
        check("after_reset_rd_data", 64'(out_rd_data), 64'h600DCAFE);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
